// File: rtl/keypad_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared sizes and scan-state encoding for the 5x5 keypad scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int KEY_ROWS   = 5;
    localparam int KEY_COLS   = 5;
    localparam int KEY_NUM    = 25;
    localparam int KEY_CODE_W = 5;
    localparam int KEY_COL_W  = 3;

    typedef enum logic [1:0] {
        ST_DRIVE     = 2'd0,
        ST_SAMPLE    = 2'd1,
        ST_FRAME_END = 2'd2
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/key_prio_enc.sv
// ============================================================================
// Module   : key_prio_enc
// Brief    : Combinational lowest-set-bit encoder over the 25-key vector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_prio_enc
    import keypad_pkg::*;
(
    input  logic [KEY_NUM-1:0]    vec,
    output logic [KEY_CODE_W-1:0] idx,
    output logic                  nz
);

    // Scan downwards so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = KEY_CODE_W'(i);
            end
        end
    end

    assign nz = |vec;

endmodule

`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
// ============================================================================
// Module   : keypad_matrix_scanner
// Brief    : 5x5 button-matrix scanner with frame debounce and press/release
//            event handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int DWELL_CYCLES    = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_en,
    output logic [KEY_COLS-1:0]   btn_x,
    input  logic [KEY_ROWS-1:0]   btn_y,
    output logic [KEY_NUM-1:0]    key_state,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_press
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int STB_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [CNT_W-1:0]     c_cnt_last = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [KEY_COL_W-1:0] c_col_last = KEY_COL_W'(KEY_COLS - 1);

    scan_state_t            r_state;
    scan_state_t            w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [KEY_COL_W-1:0]   r_col;
    logic [KEY_NUM-1:0]     r_frame;
    logic [KEY_NUM-1:0]     r_last_frame;
    logic [STB_W-1:0]       r_stable;
    logic [KEY_NUM-1:0]     r_key_state;
    logic [KEY_NUM-1:0]     r_reported;
    logic                   r_valid;
    logic [KEY_CODE_W-1:0]  r_code;
    logic                   r_press;
    logic [KEY_NUM-1:0]     w_diff;
    logic [KEY_CODE_W-1:0]  w_idx;
    logic                   w_nz;
    logic [KEY_COLS-1:0]    w_col_onehot;

    // ---------------- scan sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_DRIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (scan_en) begin
            case (r_state)
                ST_DRIVE:     if (r_cnt == c_cnt_last) w_state_nxt = ST_SAMPLE;
                ST_SAMPLE:    w_state_nxt = (r_col == c_col_last) ? ST_FRAME_END : ST_DRIVE;
                ST_FRAME_END: w_state_nxt = ST_DRIVE;
                default:      w_state_nxt = ST_DRIVE;
            endcase
        end
    end

    // Counter, column, frame capture and debounce all freeze with scan_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_col        <= '0;
            r_frame      <= '0;
            r_last_frame <= '0;
            r_stable     <= '0;
            r_key_state  <= '0;
        end else if (scan_en) begin
            case (r_state)
                ST_DRIVE: r_cnt <= r_cnt + 1'b1;
                ST_SAMPLE: begin
                    r_frame[int'(r_col) * KEY_ROWS +: KEY_ROWS] <= ~btn_y;
                    r_cnt <= '0;
                    if (r_col != c_col_last) r_col <= r_col + 1'b1;
                end
                ST_FRAME_END: begin
                    r_col <= '0;
                    if (r_frame != r_last_frame) begin
                        r_stable     <= '0;
                        r_last_frame <= r_frame;
                    end else begin
                        if (int'(r_stable) < DEBOUNCE_FRAMES - 1) r_stable <= r_stable + 1'b1;
                        if (DEBOUNCE_FRAMES > 1 && int'(r_stable) == DEBOUNCE_FRAMES - 2)
                            r_key_state <= r_frame;
                    end
                    // A single-frame debounce simply passes every frame through.
                    if (DEBOUNCE_FRAMES == 1) r_key_state <= r_frame;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign w_col_onehot = {{(KEY_COLS-1){1'b0}}, 1'b1} << r_col;
    assign btn_x        = scan_en ? ~w_col_onehot : {KEY_COLS{1'b1}};

    // ---------------- event generation ----------------
    assign w_diff = r_key_state ^ r_reported;

    key_prio_enc u_prio (
        .vec (w_diff),
        .idx (w_idx),
        .nz  (w_nz)
    );

    // reported only tracks accepted events, so any intermediate change that
    // happened while an event was stalled is delivered afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reported <= '0;
            r_valid    <= 1'b0;
            r_code     <= '0;
            r_press    <= 1'b0;
        end else if (r_valid) begin
            if (key_ready) begin
                r_reported[r_code] <= r_press;
                r_valid            <= 1'b0;
            end
        end else if (w_nz) begin
            r_valid <= 1'b1;
            r_code  <= w_idx;
            r_press <= r_key_state[w_idx];
        end
    end

    assign key_state = r_key_state;
    assign key_valid = r_valid;
    assign key_code  = r_code;
    assign key_press = r_press;

endmodule

`default_nettype wire
